// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing and instruction fetch for the unpipelined MIPS core.
// Fetches over a req/ack handshake, holds the word while it executes, faults on imem timeout.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        BranchE,
  input  logic        BranchNE,
  input  logic        Jump,
  input  logic        alu_zero,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic        commit,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {
    REQ,
    EXEC,
    HALT
  } fetchState_e;

  localparam logic [7:0] LastWait = 8'(MAX_WAIT - 1);

  fetchState_e state;
  fetchState_e stateNext;
  logic [31:0] pcReg;
  logic [31:0] pcNext;
  logic [31:0] instrReg;
  logic [31:0] instrNext;
  logic [7:0]  waitCnt;
  logic [7:0]  waitNext;
  logic        faultReg;
  logic        faultNext;
  logic [31:0] pcPlus4;
  logic [31:0] targetPc;
  logic [31:0] branchOff;
  logic        taken;

  assign pcPlus4   = pcReg + 32'd4;
  assign branchOff = {{14{instrReg[15]}}, instrReg[15:0], 2'b00};
  assign taken     = (BranchE & alu_zero) | (BranchNE & ~alu_zero);

  // Next-PC select: jump beats a taken branch, which beats fall-through.
  always_comb begin
    targetPc = pcPlus4;
    priority case (1'b1)
      Jump:    targetPc = {pcPlus4[31:28], instrReg[25:0], 2'b00};
      taken:   targetPc = pcPlus4 + branchOff;
      default: targetPc = pcPlus4;
    endcase
  end

  // Fetch FSM next-state and datapath next values.
  always_comb begin
    stateNext = state;
    pcNext    = pcReg;
    instrNext = instrReg;
    waitNext  = waitCnt;
    faultNext = faultReg;
    unique case (state)
      REQ: begin
        if (imem_ack) begin
          instrNext = imem_rdata;
          waitNext  = 8'd0;
          stateNext = EXEC;
        end else if (waitCnt == LastWait) begin
          faultNext = 1'b1;
          stateNext = HALT;
        end else begin
          waitNext = waitCnt + 8'd1;
        end
      end
      EXEC: begin
        if (!stall) begin
          pcNext    = targetPc;
          stateNext = REQ;
        end
      end
      HALT: begin
        stateNext = HALT;
      end
      default: begin
        stateNext = REQ;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= REQ;
      pcReg    <= RESET_PC;
      instrReg <= 32'd0;
      waitCnt  <= 8'd0;
      faultReg <= 1'b0;
    end else begin
      state    <= stateNext;
      pcReg    <= pcNext;
      instrReg <= instrNext;
      waitCnt  <= waitNext;
      faultReg <= faultNext;
    end
  end

  assign imem_req    = (state == REQ) & ~reset;
  assign instr_valid = (state == EXEC) & ~reset;
  assign commit      = instr_valid & ~stall;
  assign imem_addr   = pcReg;
  assign pc          = pcReg;
  assign pc_plus4    = pcPlus4;
  assign instr       = instrReg;
  assign fault       = faultReg;
  assign opcode      = instr_valid ? instrReg[31:26] : 6'b111111;

endmodule
